// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: merges pipeline writebacks with buffered
// long-latency results, preserving write ordering and bounding starvation.
module wb_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p_we,
  input  logic [4:0]  p_waddr,
  input  logic [31:0] p_wdata,
  input  logic        l_valid,
  output logic        l_ready,
  input  logic [4:0]  l_waddr,
  input  logic [31:0] l_wdata,
  output logic        stall_req,
  output logic        we,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic        pend_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0]  STARVE_C = 4'(STARVE_LIMIT);

  logic [AW-1:0]         rd_ptr, wr_ptr;
  logic [AW:0]           count;
  logic [3:0]            wait_cnt;
  logic [FIFO_DEPTH-1:0] live;
  logic [4:0]            q_addr [FIFO_DEPTH];
  logic [31:0]           q_data [FIFO_DEPTH];

  logic nonempty, head_live, forced, p_req, head_gnt, p_gnt, pop, push, can_push;

  always_comb begin
    nonempty  = (count != '0);
    head_live = nonempty && live[rd_ptr];
    forced    = (wait_cnt >= STARVE_C);
    p_req     = p_we && (p_waddr != 5'd0);
    head_gnt  = head_live && (forced || !p_req);
    p_gnt     = p_req && !(forced && head_live);
    // A dead head drains on its own without occupying the write port.
    pop       = nonempty && (head_gnt || !live[rd_ptr]);
    can_push  = (count < DEPTH_C);
    push      = l_valid && can_push && (l_waddr != 5'd0);
  end

  // Outputs are gated by reset so an active pipeline cannot write during reset.
  always_comb begin
    we        = 1'b0;
    waddr     = 5'd0;
    wdata     = 32'd0;
    l_ready   = rst && can_push;
    stall_req = forced;
    pend_busy = nonempty;
    if (rst) begin
      if (head_gnt) begin
        we    = 1'b1;
        waddr = q_addr[rd_ptr];
        wdata = q_data[rd_ptr];
      end else if (p_gnt) begin
        we    = 1'b1;
        waddr = p_waddr;
        wdata = p_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      wait_cnt <= 4'd0;
      live     <= '0;
    end else begin
      // Buffered results are older than the pipeline write, so it supersedes them.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (p_gnt && (q_addr[i] == p_waddr)) live[i] <= 1'b0;
      end
      if (pop) begin
        live[rd_ptr] <= 1'b0;
        rd_ptr       <= rd_ptr + AW'(1);
      end
      if (push) begin
        live[wr_ptr] <= !(p_gnt && (l_waddr == p_waddr));
        wr_ptr       <= wr_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (head_gnt || !nonempty)
        wait_cnt <= 4'd0;
      else if (head_live && (wait_cnt != 4'hF))
        wait_cnt <= wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= l_waddr;
      q_data[wr_ptr] <= l_wdata;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, hand sequences for starvation
// and mid-operation reset, and randomized traffic against a queue model.
module tb_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int SL    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        p_we;
  logic [4:0]  p_waddr;
  logic [31:0] p_wdata;
  logic        l_valid;
  logic        l_ready;
  logic [4:0]  l_waddr;
  logic [31:0] l_wdata;
  logic        stall_req;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        pend_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .p_we(p_we), .p_waddr(p_waddr), .p_wdata(p_wdata),
    .l_valid(l_valid), .l_ready(l_ready), .l_waddr(l_waddr), .l_wdata(l_wdata),
    .stall_req(stall_req), .we(we), .waddr(waddr), .wdata(wdata),
    .pend_busy(pend_busy)
  );

  typedef struct {
    logic        pwe;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        ewe;
    logic [4:0]  ewa;
    logic [31:0] ewd;
    logic        elr;
    logic        est;
    logic        ebz;
  } vec_t;

  typedef struct {
    bit        live;
    bit [4:0]  a;
    bit [31:0] d;
  } ent_t;

  ent_t mq[$];
  int   mwait = 0;

  function automatic vec_t mk(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                              input logic lv, input logic [4:0] la, input logic [31:0] ld,
                              input logic ewe, input logic [4:0] ewa, input logic [31:0] ewd,
                              input logic elr, input logic est, input logic ebz);
    vec_t v;
    v.pwe = pwe; v.pa = pa; v.pd = pd; v.lv = lv; v.la = la; v.ld = ld;
    v.ewe = ewe; v.ewa = ewa; v.ewd = ewd; v.elr = elr; v.est = est; v.ebz = ebz;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    p_we = v.pwe; p_waddr = v.pa; p_wdata = v.pd;
    l_valid = v.lv; l_waddr = v.la; l_wdata = v.ld;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_we"}, {31'd0, we}, 32'd0);
    chk({tag, "_waddr"}, {27'd0, waddr}, 32'd0);
    chk({tag, "_wdata"}, wdata, 32'd0);
    chk({tag, "_l_ready"}, {31'd0, l_ready}, 32'd0);
    chk({tag, "_stall"}, {31'd0, stall_req}, 32'd0);
    chk({tag, "_busy"}, {31'd0, pend_busy}, 32'd0);
  endtask

  // Reference: oldest-first queue; a pipeline write supersedes older pending
  // writes to the same register; a result waiting too long takes the port.
  task automatic model_step();
    bit forced, hl, preq, hg, pg, lr, push, pop, was_empty;
    bit        e_we;
    bit [4:0]  e_wa;
    bit [31:0] e_wd;
    ent_t e;
    if (!rst) begin
      chk_zero("m_rst");
      mq.delete();
      mwait = 0;
      return;
    end
    was_empty = (mq.size() == 0);
    forced = (mwait >= SL);
    hl     = !was_empty && mq[0].live;
    preq   = p_we && (p_waddr != 0);
    hg     = hl && (forced || !preq);
    pg     = preq && !(forced && hl);
    lr     = (mq.size() < DEPTH);
    e_we = 0; e_wa = 0; e_wd = 0;
    if (hg) begin
      e_we = 1; e_wa = mq[0].a; e_wd = mq[0].d;
    end else if (pg) begin
      e_we = 1; e_wa = p_waddr; e_wd = p_wdata;
    end
    chk("m_we", {31'd0, we}, {31'd0, e_we});
    chk("m_waddr", {27'd0, waddr}, {27'd0, e_wa});
    chk("m_wdata", wdata, e_wd);
    chk("m_l_ready", {31'd0, l_ready}, {31'd0, lr});
    chk("m_stall", {31'd0, stall_req}, {31'd0, forced});
    chk("m_busy", {31'd0, pend_busy}, {31'd0, !was_empty});
    pop  = !was_empty && (hg || !mq[0].live);
    push = l_valid && lr && (l_waddr != 0);
    if (pg) foreach (mq[i]) if (mq[i].a == p_waddr) mq[i].live = 0;
    if (pop) void'(mq.pop_front());
    if (push) begin
      e.live = !(pg && (l_waddr == p_waddr));
      e.a = l_waddr;
      e.d = l_wdata;
      mq.push_back(e);
    end
    if (hg || was_empty) mwait = 0;
    else if (hl && mwait < 15) mwait++;
  endtask

  task automatic run_cycle(input bit has_exp, input vec_t v, input string tag);
    @(negedge clk);
    if (has_exp) begin
      chk({tag, "_we"}, {31'd0, we}, {31'd0, v.ewe});
      chk({tag, "_waddr"}, {27'd0, waddr}, {27'd0, v.ewa});
      chk({tag, "_wdata"}, wdata, v.ewd);
      chk({tag, "_l_ready"}, {31'd0, l_ready}, {31'd0, v.elr});
      chk({tag, "_stall"}, {31'd0, stall_req}, {31'd0, v.est});
      chk({tag, "_busy"}, {31'd0, pend_busy}, {31'd0, v.ebz});
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[22];
  vec_t v;
  vec_t none;

  initial begin
    none = mk(0,0,0, 0,0,0, 0,0,0, 0,0,0);
    // idle writeback of a long-latency result
    tbl[0]  = mk(0,0,0,       1,5,32'h1234, 0,0,0,            1,0,0);
    tbl[1]  = mk(0,0,0,       0,0,0,        1,5,32'h1234,     1,0,1);
    tbl[2]  = mk(0,0,0,       0,0,0,        0,0,0,            1,0,0);
    // buffered x9 superseded by a later pipeline write, then same-cycle variant
    tbl[3]  = mk(0,0,0,       1,9,32'h11,   0,0,0,            1,0,0);
    tbl[4]  = mk(1,9,32'h22,  0,0,0,        1,9,32'h22,       1,0,1);
    tbl[5]  = mk(0,0,0,       0,0,0,        0,0,0,            1,0,1);
    tbl[6]  = mk(0,0,0,       0,0,0,        0,0,0,            1,0,0);
    tbl[7]  = mk(1,9,32'h33,  1,9,32'h44,   1,9,32'h33,       1,0,0);
    tbl[8]  = mk(0,0,0,       0,0,0,        0,0,0,            1,0,1);
    tbl[9]  = mk(0,0,0,       0,0,0,        0,0,0,            1,0,0);
    // writes to x0 from either source are dropped
    tbl[10] = mk(1,0,32'hDEAD, 1,0,32'hBEEF, 0,0,0,           1,0,0);
    tbl[11] = mk(1,0,32'hDEAD, 1,0,32'hBEEF, 0,0,0,           1,0,0);
    // fill the buffer behind a busy pipeline; third result waits for space
    tbl[12] = mk(1,3,32'h100, 1,10,32'hA,   1,3,32'h100,      1,0,0);
    tbl[13] = mk(1,3,32'h101, 1,11,32'hB,   1,3,32'h101,      1,0,1);
    tbl[14] = mk(1,3,32'h102, 1,12,32'hC,   1,3,32'h102,      0,0,1);
    tbl[15] = mk(1,3,32'h103, 1,12,32'hC,   1,3,32'h103,      0,0,1);
    tbl[16] = mk(1,3,32'h104, 1,12,32'hC,   1,3,32'h104,      0,0,1);
    tbl[17] = mk(1,3,32'h105, 1,12,32'hC,   1,10,32'hA,       0,1,1);
    tbl[18] = mk(1,3,32'h105, 1,12,32'hC,   1,3,32'h105,      1,0,1);
    tbl[19] = mk(0,0,0,       0,0,0,        1,11,32'hB,       0,0,1);
    tbl[20] = mk(0,0,0,       0,0,0,        1,12,32'hC,       1,0,1);
    tbl[21] = mk(0,0,0,       0,0,0,        0,0,0,            1,0,0);

    rst = 1'b0;
    apply(mk(1,3,32'h55, 1,5,32'h66, 0,0,0, 0,0,0));
    #2;
    chk_zero("init_rst");
    run_cycle(0, none, "rst0");
    run_cycle(0, none, "rst1");
    rst = 1'b1;

    for (int i = 0; i < 22; i++) begin
      apply(tbl[i]);
      run_cycle(1, tbl[i], $sformatf("row%0d", i));
    end

    // starvation: pipeline hammers x3 until the buffered x7 is forced out
    v = mk(1,3,32'h300, 1,7,32'hAA, 1,3,32'h300, 1,0,0);
    apply(v); run_cycle(1, v, "starve_push");
    for (int k = 1; k <= SL; k++) begin
      v = mk(1,3,32'h300 + k, 0,0,0, 1,3,32'h300 + k, 1,0,1);
      apply(v); run_cycle(1, v, $sformatf("starve_wait%0d", k));
    end
    v = mk(1,3,32'h3FF, 0,0,0, 1,7,32'hAA, 1,1,1);
    apply(v); run_cycle(1, v, "starve_forced");
    v = mk(1,3,32'h3FF, 0,0,0, 1,3,32'h3FF, 1,0,0);
    apply(v); run_cycle(1, v, "starve_after");

    // reset with two results buffered
    v = mk(1,3,32'h400, 1,20,32'h1, 1,3,32'h400, 1,0,0);
    apply(v); run_cycle(1, v, "rb_push0");
    v = mk(1,3,32'h401, 1,21,32'h2, 1,3,32'h401, 1,0,1);
    apply(v); run_cycle(1, v, "rb_push1");
    apply(mk(1,3,32'h402, 0,0,0, 0,0,0, 0,0,0));
    #1 rst = 1'b0;
    #1 chk_zero("midrst");
    mq.delete();
    mwait = 0;
    run_cycle(0, none, "midrst0");
    run_cycle(0, none, "midrst1");
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      v = mk(0,0,0, 0,0,0, 0,0,0, 1,0,0);
      apply(v); run_cycle(1, v, $sformatf("post_rst%0d", k));
    end

    // randomized traffic; the pipeline holds its request while stalled
    for (int n = 0; n < 2000; n++) begin
      if (mwait < SL) begin
        p_we    = ($urandom_range(0, 3) != 0);
        p_waddr = 5'($urandom_range(0, 3));
        p_wdata = $urandom;
      end
      l_valid = ($urandom_range(0, 2) == 0);
      l_waddr = 5'($urandom_range(0, 3));
      l_wdata = $urandom;
      run_cycle(0, none, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
